// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Control unit for a multi-cycle RV32I core. A FETCH/DECODE/EXEC/MEM/WB
//   state machine drives the datapath through write enables. There are no
//   derived clocks. The block owns the instruction register. It handshakes a
//   single-port memory with req/ready and a bounded number of wait states.
//   Illegal instructions and memory timeouts send it to a sticky TRAP state.
//
//   Ports
//     clk, rst            clock (rising edge), asynchronous active-high reset
//     mem_rdata[31:0]     memory read data, latched into IR in FETCH
//     mem_ready           memory finishes the current request this cycle
//     LU, LS, EQ          ALU compare flags (unsigned <, signed <, equal)
//     mem_req, mem_we     memory request / store qualifier
//     addr_sel            0 = address from PC, 1 = address from ALU
//     pc_we, rd_we        PC / register-file write enables (1-cycle pulses)
//     pc_next_sel         0 = PC+4, 1 = ALU result
//     alu_sel_a/b         a: 0 rs1 / 1 PC ; b: 0 rs2 / 1 imm
//     sub_sra             insn[30] for OP and SRAI/SRLI, else 0
//     imm[31:0]           sign-extended immediate (I/S/B/U/J)
//     func[2:0]           ALU op (funct3 for OP/OP-IMM, add otherwise)
//     rd_sel[1:0]         0 ALU, 1 memory, 2 PC+4, 3 imm
//     mem_size, mem_extend  insn[13:12], insn[14:12]
//     rs1, rs2, rd        register addresses from IR
//     state[2:0], trap    FSM state (debug), sticky trap flag
//     instret[CNT_W-1:0]  retired-instruction counter (wraps)
module multicycle_control_fsm #(
  parameter int unsigned WAIT_LIMIT = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  input  logic             LU,
  input  logic             LS,
  input  logic             EQ,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             pc_we,
  output logic             rd_we,
  output logic             pc_next_sel,
  output logic             alu_sel_a,
  output logic             alu_sel_b,
  output logic             sub_sra,
  output logic [31:0]      imm,
  output logic [2:0]       func,
  output logic [1:0]       rd_sel,
  output logic [1:0]       mem_size,
  output logic [2:0]       mem_extend,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [2:0]       state,
  output logic             trap,
  output logic [CNT_W-1:0] instret
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] TRAP   = 3'd5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  // Last wait count before a stalled access gives up. Unused when WAIT_LIMIT is 0.
  localparam logic [31:0] WAIT_LAST = (WAIT_LIMIT == 0) ? 32'd0 : WAIT_LIMIT - 32'd1;

  logic [2:0]       state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [31:0]      waitCnt_q, waitCnt_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       isLui, isAuipc, isJal, isJalr, isBranch, isLoad, isStore;
  logic       isOpImm, isOp, isFence, isLegal;
  logic       inFetch, inMem, memStall, waitHit, branchTaken;

  // Opcode classification of the latched instruction.
  assign opcode   = ir_q[6:0];
  assign funct3   = ir_q[14:12];
  assign isLui    = (opcode == OPC_LUI);
  assign isAuipc  = (opcode == OPC_AUIPC);
  assign isJal    = (opcode == OPC_JAL);
  assign isJalr   = (opcode == OPC_JALR);
  assign isBranch = (opcode == OPC_BRANCH);
  assign isLoad   = (opcode == OPC_LOAD);
  assign isStore  = (opcode == OPC_STORE);
  assign isOpImm  = (opcode == OPC_OPIMM);
  assign isOp     = (opcode == OPC_OP);
  assign isFence  = (opcode == OPC_FENCE);
  // SYSTEM (ECALL/EBREAK/CSR) is not supported, so it counts as illegal.
  assign isLegal  = isLui | isAuipc | isJal | isJalr | isBranch | isLoad |
                    isStore | isOpImm | isOp | isFence;

  assign inFetch  = (state_q == FETCH);
  assign inMem    = (state_q == MEM);
  assign memStall = (inFetch | inMem) & ~mem_ready;
  assign waitHit  = memStall & (WAIT_LIMIT != 0) & (waitCnt_q == WAIT_LAST);

  // Branch condition selected by funct3. The reserved encodings are never taken.
  always_comb begin
    branchTaken = 1'b0;
    case (funct3)
      3'b000:  branchTaken = EQ;
      3'b001:  branchTaken = ~EQ;
      3'b100:  branchTaken = LS;
      3'b101:  branchTaken = ~LS;
      3'b110:  branchTaken = LU;
      3'b111:  branchTaken = ~LU;
      default: branchTaken = 1'b0;
    endcase
  end

  // Next-state logic. IR only loads on a completed fetch.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = DECODE;
        end else if (waitHit) begin
          state_d = TRAP;
        end
      end
      DECODE: state_d = isLegal ? EXEC : TRAP;
      EXEC: begin
        if (isBranch)                state_d = FETCH;
        else if (isLoad || isStore)  state_d = MEM;
        else                         state_d = WB;
      end
      MEM: begin
        if (mem_ready)    state_d = isStore ? FETCH : WB;
        else if (waitHit) state_d = TRAP;
      end
      WB:      state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = TRAP;
    endcase
  end

  // The wait counter only runs while a request is outstanding and unanswered.
  // It therefore starts from zero on every entry to FETCH or MEM.
  always_comb begin
    waitCnt_d = 32'd0;
    if (memStall && (WAIT_LIMIT != 0)) waitCnt_d = waitCnt_q + 32'd1;
  end

  // Each retirement coincides with exactly one PC write.
  assign instret_d = instret_q + CNT_W'(pc_we);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      ir_q      <= 32'd0;
      instret_q <= '0;
      waitCnt_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // Memory strobes are gated by rst so that reset drops a pending access
  // at once, including the FETCH state the machine resets into.
  assign mem_req  = ~rst & (inFetch | inMem);
  assign mem_we   = ~rst & inMem & isStore;
  assign addr_sel = ~rst & inMem;

  assign pc_we = ((state_q == EXEC) & isBranch) |
                 (inMem & isStore & mem_ready) |
                 (state_q == WB);
  assign rd_we = (state_q == WB) & ~isFence & (ir_q[11:7] != 5'd0);

  // pc_next_sel is the only output that depends on the compare flags.
  assign pc_next_sel = ((state_q == EXEC) & isBranch & branchTaken) |
                       ((state_q == WB) & (isJal | isJalr));

  // Branch targets, JAL and AUIPC add imm to the PC. Branch flags come from a
  // separate rs1/rs2 comparator, so the ALU is free to form the target.
  assign alu_sel_a = isAuipc | isJal | isBranch;
  assign alu_sel_b = isOpImm | isLoad | isStore | isJalr | isJal | isAuipc |
                     isLui | isBranch;
  assign sub_sra   = (isOp & ir_q[30]) | (isOpImm & (funct3 == 3'b101) & ir_q[30]);
  assign func      = (isOp | isOpImm) ? funct3 : 3'b000;

  always_comb begin
    rd_sel = 2'd0;
    if (isLoad)              rd_sel = 2'd1;
    else if (isJal | isJalr) rd_sel = 2'd2;
    else if (isLui)          rd_sel = 2'd3;
  end

  // Immediate assembly for each instruction format.
  always_comb begin
    imm = 32'd0;
    if (isOpImm | isLoad | isJalr)
      imm = {{20{ir_q[31]}}, ir_q[31:20]};
    else if (isStore)
      imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    else if (isBranch)
      imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    else if (isLui | isAuipc)
      imm = {ir_q[31:12], 12'd0};
    else if (isJal)
      imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  end

  assign mem_size   = ir_q[13:12];
  assign mem_extend = ir_q[14:12];
  assign rs1        = ir_q[19:15];
  assign rs2        = ir_q[24:20];
  assign rd         = ir_q[11:7];
  assign state      = state_q;
  assign trap       = (state_q == TRAP);
  assign instret    = instret_q;

endmodule
